// File: rtl/weighted_rr_arbiter_if.sv
// weighted_rr_arbiter_if: request/ack/grant bundle between masters, the arbiter and the sink
interface weighted_rr_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int WEIGHT_W = 4
);
  localparam int ID_W = $clog2(WIDTH);
  logic [WIDTH-1:0]          request;
  logic [WIDTH*WEIGHT_W-1:0] weight;
  logic                      ack;
  logic [WIDTH-1:0]          grant;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;
  logic [WEIGHT_W-1:0]       credit_left;
  modport master (output request, weight, ack, input grant, grant_valid, grant_id, credit_left);
  modport slave  (input request, weight, ack, output grant, grant_valid, grant_id, credit_left);
endinterface

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: weighted round-robin arbiter holding each grant for a burst of acked beats
module weighted_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int WEIGHT_W = 4,
  localparam int ID_W    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  weighted_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [WIDTH-1:0] LSB = WIDTH'(1);
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    grant_q, grant_d, mask, masked, pool;
  logic [ID_W-1:0]     id_q, id_d, last_q, last_d, win;
  logic [WEIGHT_W-1:0] credit_q, credit_d, w_win;
  logic                rel, load;
  // Requesters strictly above the last grantee rank first; otherwise wrap to the lowest index.
  always_comb begin
    mask   = ~((LSB << last_q) | ((LSB << last_q) - LSB));
    masked = bus.request & mask;
    pool   = (|masked) ? masked : bus.request;
    win    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) win = pool[i] ? ID_W'(i) : win;
    w_win  = bus.weight[win*WEIGHT_W +: WEIGHT_W];
    rel    = (state_q == GRANT) && ((bus.ack && credit_q == WEIGHT_W'(1)) || !bus.request[id_q]);
    load   = (state_q == IDLE || rel) && (|bus.request);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      credit_q <= '0;
      last_q   <= ID_W'(WIDTH - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      credit_q <= credit_d;
      last_q   <= last_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE || rel) ? ((|bus.request) ? GRANT : IDLE) : state_q;
  end
  always_comb begin
    grant_d  = load ? LSB << win : (state_d == IDLE ? '0 : grant_q);
    id_d     = load ? win : (state_d == IDLE ? '0 : id_q);
    credit_d = load ? (w_win == '0 ? WEIGHT_W'(1) : w_win)
             : state_d == IDLE ? '0
             : (bus.ack && state_q == GRANT) ? credit_q - WEIGHT_W'(1) : credit_q;
    last_d   = load ? win : last_q;
  end
  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = id_q;
  assign bus.credit_left = credit_q;
endmodule
